// File: rtl/simon_bs_core_gen.sv
// simon_bs_core_gen -- bit-serial SIMON block cipher core (N-bit words, 2N-bit block).
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   data_in/data_valid/data_ready   plaintext stream: y word then x word, LSB first
//   key_in/key_req           one round-key bit per RUN cycle (bit j of round r at cycle r*N+j)
//   ct_out/ct_valid/ct_ready/ct_last  ciphertext stream: y then x, LSB first
//   busy                     high outside IDLE
//   rol8_ext/rol8_out        cross-share S8 tap, only with SIMON_CROSS_SHARE_EN defined
//
// Optional feature macro: SIMON_CROSS_SHARE_EN. When defined, two lockstep instances
// cross-wired through rol8_ext/rol8_out form a 2-share threshold implementation.
//
// One new x bit is produced per RUN cycle and written in place over y[j]; y[j] is not
// read again this round, and x stays untouched until the round boundary, so all
// rotation taps see the round's input x. At bit N-1 the words swap (x' -> x, x -> y).
module simon_bs_core_gen #(
  parameter int N      = 16,
  parameter int ROUNDS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  input  logic data_valid,
  output logic data_ready,
  input  logic key_in,
  output logic key_req,
  output logic ct_out,
  output logic ct_valid,
  input  logic ct_ready,
  output logic ct_last,
`ifdef SIMON_CROSS_SHARE_EN
  input  logic rol8_ext,
  output logic rol8_out,
`endif
  output logic busy
);
  localparam int BW = $clog2(N);
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int PW = $clog2(2 * N);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(2 * N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OUT} state_t;

  state_t        r_state, w_next;
  logic [N-1:0]  r_x, r_y;
  logic [BW-1:0] r_bit;
  logic [RW-1:0] r_rnd;
  logic [PW-1:0] r_pos;   // serial position during LOAD and OUT

  logic [N-1:0]  w_r1, w_r2, w_r8, w_y_upd;
  logic          w_in_xfer, w_ct_xfer, w_last, w_cross, w_newbit;

  // Rotated copies of x; indexing them with r_bit gives Sn x [j].
  assign w_r1 = {r_x[N-2:0], r_x[N-1]};
  assign w_r2 = {r_x[N-3:0], r_x[N-1:N-2]};
  assign w_r8 = {r_x[N-9:0], r_x[N-1:N-8]};

`ifdef SIMON_CROSS_SHARE_EN
  // Cross product with the other share's S8 tap completes the shared AND.
  assign w_cross  = w_r1[r_bit] & rol8_ext;
  assign rol8_out = (r_state == S_RUN) ? w_r8[r_bit] : 1'b0;
`else
  assign w_cross  = 1'b0;
`endif

  assign w_newbit = r_y[r_bit] ^ w_r2[r_bit] ^ (w_r1[r_bit] & w_r8[r_bit]) ^ key_in ^ w_cross;

  always_comb begin
    w_y_upd        = r_y;
    w_y_upd[r_bit] = w_newbit;
  end

  assign w_in_xfer = data_valid & data_ready;
  assign w_ct_xfer = ct_valid & ct_ready;
  assign w_last    = (r_pos == POS_LAST);
  assign ct_out    = (r_state == S_OUT) ? r_y[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    data_ready = 1'b0;
    key_req    = 1'b0;
    ct_valid   = 1'b0;
    ct_last    = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        data_ready = 1'b1;
        busy       = 1'b0;
        if (data_valid) w_next = S_LOAD;
      end
      S_LOAD: begin
        data_ready = 1'b1;
        if (data_valid && w_last) w_next = S_RUN;
      end
      S_RUN: begin
        key_req = 1'b1;
        if (r_bit == BIT_LAST && r_rnd == RND_LAST) w_next = S_OUT;
      end
      S_OUT: begin
        ct_valid = 1'b1;
        ct_last  = w_last;
        if (ct_ready && w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_bit <= '0;
      r_rnd <= '0;
      r_pos <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_in_xfer) begin
            // {x,y} acts as one 2N-bit right shift register fed at x MSB.
            r_x   <= {data_in, r_x[N-1:1]};
            r_y   <= {r_x[0], r_y[N-1:1]};
            r_pos <= w_last ? '0 : r_pos + 1'b1;
          end
        end
        S_RUN: begin
          if (r_bit == BIT_LAST) begin
            r_bit <= '0;
            r_rnd <= (r_rnd == RND_LAST) ? '0 : r_rnd + 1'b1;
            r_x   <= w_y_upd;
            r_y   <= r_x;
          end else begin
            r_bit <= r_bit + 1'b1;
            r_y   <= w_y_upd;
          end
        end
        S_OUT: begin
          if (w_ct_xfer) begin
            r_x   <= {1'b0, r_x[N-1:1]};
            r_y   <= {r_x[0], r_y[N-1:1]};
            r_pos <= w_last ? '0 : r_pos + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_bs_core_gen.sv
// Bench for simon_bs_core_gen: word-level SIMON model plus SIMON32/64 key schedule,
// table of block vectors over three parameterizations, hand sequences for a
// mid-run reset and (with SIMON_CROSS_SHARE_EN) the two-share configuration.
module tb_simon_bs_core_gen;
`ifdef SIMON_CROSS_SHARE_EN
  localparam int NI = 5;
  logic r8o0, r8o1, r8o2, r8o3, r8o4;
`else
  localparam int NI = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] data_in, data_valid, data_ready, key_in, key_req;
  logic [NI-1:0] ct_out, ct_valid, ct_ready, ct_last, busy;

  int nchk = 0;
  int nerr = 0;
  logic [63:0]  rk16 [72];
  logic [63:0]  rk64 [72];
  logic [127:0] sb [$];

  typedef struct {
    int           inst;
    logic [127:0] pt;
    logic [127:0] ct;
    int           stall;
    bit           dvrun;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  simon_bs_core_gen #(.N(16), .ROUNDS(32)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[0]), .data_valid(data_valid[0]),
    .data_ready(data_ready[0]), .key_in(key_in[0]), .key_req(key_req[0]),
    .ct_out(ct_out[0]), .ct_valid(ct_valid[0]), .ct_ready(ct_ready[0]), .ct_last(ct_last[0]),
`ifdef SIMON_CROSS_SHARE_EN
    .rol8_ext(1'b0), .rol8_out(r8o0),
`endif
    .busy(busy[0]));

  simon_bs_core_gen #(.N(64), .ROUNDS(68)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[1]), .data_valid(data_valid[1]),
    .data_ready(data_ready[1]), .key_in(key_in[1]), .key_req(key_req[1]),
    .ct_out(ct_out[1]), .ct_valid(ct_valid[1]), .ct_ready(ct_ready[1]), .ct_last(ct_last[1]),
`ifdef SIMON_CROSS_SHARE_EN
    .rol8_ext(1'b0), .rol8_out(r8o1),
`endif
    .busy(busy[1]));

  simon_bs_core_gen #(.N(16), .ROUNDS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[2]), .data_valid(data_valid[2]),
    .data_ready(data_ready[2]), .key_in(key_in[2]), .key_req(key_req[2]),
    .ct_out(ct_out[2]), .ct_valid(ct_valid[2]), .ct_ready(ct_ready[2]), .ct_last(ct_last[2]),
`ifdef SIMON_CROSS_SHARE_EN
    .rol8_ext(1'b0), .rol8_out(r8o2),
`endif
    .busy(busy[2]));

`ifdef SIMON_CROSS_SHARE_EN
  simon_bs_core_gen #(.N(16), .ROUNDS(32)) u3 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[3]), .data_valid(data_valid[3]),
    .data_ready(data_ready[3]), .key_in(key_in[3]), .key_req(key_req[3]),
    .ct_out(ct_out[3]), .ct_valid(ct_valid[3]), .ct_ready(ct_ready[3]), .ct_last(ct_last[3]),
    .rol8_ext(r8o4), .rol8_out(r8o3), .busy(busy[3]));

  simon_bs_core_gen #(.N(16), .ROUNDS(32)) u4 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in[4]), .data_valid(data_valid[4]),
    .data_ready(data_ready[4]), .key_in(key_in[4]), .key_req(key_req[4]),
    .ct_out(ct_out[4]), .ct_valid(ct_valid[4]), .ct_ready(ct_ready[4]), .ct_last(ct_last[4]),
    .rol8_ext(r8o3), .rol8_out(r8o4), .busy(busy[4]));
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
    logic [63:0] m;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    return ((v << s) | (v >> (n - s))) & m;
  endfunction

  // Instance 3 is the zero-key share; 1 uses the N=64 keys; others the SIMON32/64 keys.
  function automatic logic [63:0] rkey(input int id, input int r);
    case (id)
      1:       return rk64[r];
      3:       return 64'd0;
      default: return rk16[r];
    endcase
  endfunction

  function automatic logic [127:0] model(input int id, input int n, input int rounds,
                                         input logic [127:0] pt);
    logic [63:0] m, x, y, t;
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    x = 64'(pt >> n) & m;
    y = 64'(pt) & m;
    for (int r = 0; r < rounds; r++) begin
      t = x;
      x = y ^ rotl(x, 2, n) ^ (rotl(x, 1, n) & rotl(x, 8, n)) ^ rkey(id, r);
      y = t;
    end
    return (128'(x) << n) | 128'(y);
  endfunction

  task automatic ks32(input logic [63:0] key);
    logic [61:0] z0;
    logic [15:0] k [72];
    logic [15:0] t;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 4; i < 72; i++) begin
      t = {k[i-1][2:0], k[i-1][15:3]};
      t = t ^ k[i-3];
      t = t ^ {t[0], t[15:1]};
      k[i] = ~k[i-4] ^ t ^ {15'd0, z0[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
    for (int i = 0; i < 72; i++) rk16[i] = {48'd0, k[i]};
  endtask

  // Drives one block through instance a (and b in lockstep when a != b), feeding key
  // bits on key_req, collecting ct, and comparing against the scoreboard head.
  // rst_at >= 0 pulls reset at that RUN cycle and discards the block.
  task automatic run_blk(input string nm, input int a, input int b, input int n, input int rounds,
                         input logic [127:0] pta, input logic [127:0] ptb, input logic [127:0] expct,
                         input int stall, input bit dvrun, input int rst_at);
    int cyc = 0, li = 0, kc = 0, oi = 0, first_ct = -1;
    int limit = 8 * n + rounds * n + 50;
    logic [127:0] cta = '0, ctb = '0;
    logic [63:0]  kw;
    bit done = 0, bad_busy = 0, bad_last = 0, bad_rdy = 0, bad_stall = 0, hold = 0;
    logic prev = 1'b0;
    logic rdy;
    sb.push_back(expct);
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({nm, "/idle"}, 128'({busy[a], ct_valid[a], data_ready[a]}), 128'(3'b001));
      else if (!busy[a]) bad_busy = 1;
      if (li < 2 * n) begin
        data_valid[a] = 1'b1; data_in[a] = pta[li];
        data_valid[b] = 1'b1; data_in[b] = ptb[li];
        li++;
      end else begin
        data_valid[a] = dvrun; data_in[a] = 1'($urandom);
        data_valid[b] = dvrun; data_in[b] = 1'($urandom);
      end
      if (key_req[a]) begin
        if (data_ready[a]) bad_rdy = 1;
        if (rst_at >= 0 && kc == rst_at) begin
          rst_n = 1'b0;
          data_valid[a] = 1'b0; data_valid[b] = 1'b0;
          @(negedge clk);
          chk({nm, "/rst_out"},
              128'({data_ready[a], key_req[a], ct_valid[a], ct_last[a], busy[a], ct_out[a]}),
              128'(6'b100000));
          rst_n = 1'b1;
          void'(sb.pop_front());
          return;
        end
        kw = rkey(a, kc / n); key_in[a] = kw[kc % n];
        kw = rkey(b, kc / n); key_in[b] = kw[kc % n];
        kc++;
      end else begin
        key_in[a] = 1'($urandom); key_in[b] = 1'($urandom);
      end
      if (ct_valid[a]) begin
        if (first_ct < 0) first_ct = cyc;
        if (hold && ct_out[a] !== prev) bad_stall = 1;
        rdy = !(stall != 0 && (cyc % 3 == 0));
        ct_ready[a] = rdy; ct_ready[b] = rdy;
        if (rdy) begin
          cta[oi] = ct_out[a]; ctb[oi] = ct_out[b];
          if (ct_last[a] !== (oi == 2 * n - 1)) bad_last = 1;
          oi++;
          hold = 0;
          if (oi == 2 * n) begin
            done = 1;
            data_valid[a] = 1'b0; data_valid[b] = 1'b0;
          end
        end else begin
          hold = 1; prev = ct_out[a];
        end
      end else begin
        ct_ready[a] = 1'($urandom); ct_ready[b] = ct_ready[a];
      end
    end
    chk({nm, "/done"}, 128'(done), 128'(1));
    chk({nm, "/ct"}, (a == b) ? cta : (cta ^ ctb), sb.pop_front());
    chk({nm, "/latency"}, 128'(first_ct), 128'(2 * n + rounds * n + 1));
    chk({nm, "/keybits"}, 128'(kc), 128'(rounds * n));
    chk({nm, "/ct_last"}, 128'(bad_last), 128'(0));
    chk({nm, "/busy_held"}, 128'(bad_busy), 128'(0));
    chk({nm, "/run_ready"}, 128'(bad_rdy), 128'(0));
    chk({nm, "/stall_stable"}, 128'(bad_stall), 128'(0));
  endtask

  function automatic int inst_n(input int id);
    return (id == 1) ? 64 : 16;
  endfunction

  function automatic int inst_r(input int id);
    return (id == 1) ? 68 : ((id == 2) ? 1 : 32);
  endfunction

  initial begin
    logic [127:0] p;
    data_in = '0; data_valid = '0; key_in = '0; ct_ready = '0;
    ks32(64'h1918_1110_0908_0100);
    for (int i = 0; i < 72; i++) rk64[i] = {$urandom, $urandom};

    vt[0] = '{0, 128'h6565_6877, 128'hc69b_e9bb, 0, 0};
    vt[1] = '{0, 128'h6565_6877, 128'hc69b_e9bb, 1, 0};
    p = 128'($urandom);
    vt[2] = '{0, p, model(0, 16, 32, p), 0, 1};
    p = 128'($urandom);
    vt[3] = '{0, p, model(0, 16, 32, p), 1, 1};
    p = 128'($urandom);
    vt[4] = '{2, p, model(2, 16, 1, p), 0, 0};
    p = 128'hffff_ffff;
    vt[5] = '{2, p, model(2, 16, 1, p), 1, 1};
    p = {$urandom, $urandom, $urandom, $urandom};
    vt[6] = '{1, p, model(1, 64, 68, p), 0, 0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset%0d", i),
          128'({data_ready[i], key_req[i], ct_valid[i], ct_last[i], busy[i], ct_out[i]}),
          128'(6'b100000));
`ifdef SIMON_CROSS_SHARE_EN
    chk("reset_rol8", 128'({r8o0, r8o1, r8o2, r8o3, r8o4}), 128'(0));
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_blk($sformatf("vec%0d", i), vt[i].inst, vt[i].inst, inst_n(vt[i].inst),
              inst_r(vt[i].inst), vt[i].pt, vt[i].pt, vt[i].ct, vt[i].stall, vt[i].dvrun, -1);

    run_blk("mid_reset", 0, 0, 16, 32, 128'h6565_6877, 128'h6565_6877, 128'hc69b_e9bb, 0, 0, 100);
    run_blk("after_reset", 0, 0, 16, 32, 128'h6565_6877, 128'h6565_6877, 128'hc69b_e9bb, 0, 0, -1);

`ifdef SIMON_CROSS_SHARE_EN
    run_blk("two_share", 3, 4, 16, 32, 128'h6565_6877 ^ 128'h1234_5678, 128'h1234_5678,
            128'hc69b_e9bb, 0, 0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
